// File: rtl/decade_up_pkg.sv
// Shared BCD digit types, constants and helpers for the decadic counters.
package decade_up_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-BCD codes (10..15) collapse to zero.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// One ascending BCD digit with clear, load and ripple step chaining.
module bcd_digit_up
  import decade_up_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  bcd_digit_t load_d,
  input  logic       step_in,
  output bcd_digit_t count_d,
  output logic       step_out
);

  assign step_out = step_in & (count_d == BCD_MAX);

  always_ff @(posedge clk) begin
    if (clear)
      count_d <= BCD_ZERO;
    else if (load)
      count_d <= bcd_sanitize(load_d);
    else if (step_in)
      count_d <= (count_d == BCD_MAX) ? BCD_ZERO
                                      : bcd_digit_t'(count_d + 4'd1);
  end

endmodule

// File: rtl/decade_up_counter.sv
// Multi-digit BCD up counter with load, tc and carry pulse.
// Define DECADE_UP_SATURATE_EN to hold at all-9s instead of wrapping.
module decade_up_counter
  import decade_up_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                carry_out
);

  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] is_max;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_up u_digit (
      .clk      (clk),
      .clear    (clear),
      .load     (load),
      .load_d   (load_val[4*g +: 4]),
      .step_in  (step[g]),
      .count_d  (count[4*g +: 4]),
      .step_out (step[g+1])
    );
    assign is_max[g] = (count[4*g +: 4] == BCD_MAX);
  end

  assign tc = &is_max;

`ifdef DECADE_UP_SATURATE_EN
  assign step[0] = en & ~tc;
`else
  assign step[0] = en;
`endif

  // Step rippling out of the top digit is exactly the wrap event.
  always_ff @(posedge clk) begin
    if (clear)
      carry_out <= 1'b0;
    else if (load)
      carry_out <= 1'b0;
    else
      carry_out <= step[DIGITS];
  end

endmodule

// File: tb/tb_decade_up_counter.sv
// Randomized and directed checks of decade_up_counter against a numeric model.
module tb_decade_up_counter;

  logic       clk = 1'b0;
  logic       clear, en, load;
  logic [7:0] load_val;
  logic [7:0] count2;
  logic       tc2, co2;
  logic [3:0] count1;
  logic       tc1, co1;

  int total = 0;
  int bad   = 0;
  int m2, m1;
  bit c2, c1;
  int carries1;

  always #5 clk = ~clk;

  decade_up_counter #(.DIGITS(2)) dut2 (
    .clk(clk), .clear(clear), .en(en), .load(load),
    .load_val(load_val), .count(count2), .tc(tc2), .carry_out(co2)
  );

  decade_up_counter #(.DIGITS(1)) dut1 (
    .clk(clk), .clear(clear), .en(en), .load(load),
    .load_val(load_val[3:0]), .count(count1), .tc(tc1), .carry_out(co1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v, input int nd);
    int r = 0;
    int p = 1;
    for (int i = 0; i < nd; i++) begin
      r = r | (((v / p) % 10) << (4 * i));
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_lv(input logic [7:0] lv, input int nd);
    int v = 0;
    int p = 1;
    for (int i = 0; i < nd; i++) begin
      int d;
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model(inout int m, inout bit c, input int maxv,
                       input int nd);
    if (clear) begin
      m = 0; c = 0;
    end else if (load) begin
      m = from_lv(load_val, nd); c = 0;
    end else if (en) begin
      if (m == maxv) begin
`ifdef DECADE_UP_SATURATE_EN
        c = 0;
`else
        m = 0; c = 1;
`endif
      end else begin
        m = m + 1; c = 0;
      end
    end else begin
      c = 0;
    end
  endtask

  task automatic cyc(input bit c, input bit l, input logic [7:0] lv,
                     input bit e);
    @(negedge clk);
    clear = c; load = l; load_val = lv; en = e;
    @(posedge clk);
    model(m2, c2, 99, 2);
    model(m1, c1, 9, 1);
    #1;
    check("count2", count2, to_bcd(m2, 2));
    check("tc2", tc2, m2 == 99);
    check("carry2", co2, c2);
    check("count1", count1, to_bcd(m1, 1));
    check("tc1", tc1, m1 == 9);
    check("carry1", co1, c1);
    if (co1) carries1++;
  endtask

  initial begin
    clear = 0; en = 0; load = 0; load_val = '0;
    m2 = 0; m1 = 0; c2 = 0; c1 = 0; carries1 = 0;

    cyc(1, 0, 8'h00, 0);
    repeat (3) cyc(0, 0, 8'h00, 0);
    check("reset_count", count2, 8'h00);

    repeat (12) cyc(0, 0, 8'h00, 1);
    check("count_12", count2, 8'h12);

    cyc(0, 1, 8'h97, 0);
    repeat (3) cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);

    cyc(0, 1, 8'h45, 0);
    cyc(0, 1, 8'h3C, 1);
    check("load_nonbcd", count2, 8'h30);

    cyc(0, 1, 8'h57, 0);
    cyc(1, 0, 8'h00, 1);
    check("clear_wins", count2, 8'h00);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1);
    check("resume", count2, 8'h02);

    cyc(1, 0, 8'h00, 0);
    carries1 = 0;
    repeat (20) cyc(0, 0, 8'h00, 1);
`ifdef DECADE_UP_SATURATE_EN
    check("carries_1d", carries1, 0);
`else
    check("carries_1d", carries1, 2);
`endif

    repeat (400) begin
      bit rc, rl, re;
      logic [7:0] rv;
      rc = ($urandom_range(0, 29) == 0);
      rl = ($urandom_range(0, 9) == 0);
      re = ($urandom_range(0, 3) != 0);
      rv = $urandom_range(0, 1) ? 8'h99 : 8'($urandom);
      cyc(rc, rl, rv, re);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
